// File: rtl/fp_cmp_minmax_seq_if.sv
// Element-in / result-out stream bundle for fp_cmp_minmax_seq.
// master: element producer and result consumer; slave: the min/max block.
interface fp_cmp_minmax_seq_if #(
  parameter int IDX_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_value;
  logic [IDX_W-1:0] out_idx;
  logic             out_nan;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_value, out_idx, out_nan
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_value, out_idx, out_nan
  );
endinterface

// File: rtl/fp_cmp_minmax_seq.sv
// Running min/max of an IEEE-754 single stream via an external magnitude
// comparator of CMP_LAT cycles latency; reports value, index and NaN flag.
// Ports: clk, rst (async high), mode (0 min / 1 max, sampled on first
// element), io (element/result streams), cmp_a_*/cmp_b_* operand outputs,
// cmp_res comparator result ({A} < {B} unsigned magnitude).
module fp_cmp_minmax_seq #(
  parameter int CMP_LAT = 1,
  parameter int IDX_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  fp_cmp_minmax_seq_if.slave    io,
  output logic [7:0]            cmp_a_exp,
  output logic [22:0]           cmp_a_man,
  output logic [7:0]            cmp_b_exp,
  output logic [22:0]           cmp_b_man,
  input  logic                  cmp_res
);

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    WAIT,
    DONE
  } state_e;

  localparam logic [2:0]  WAIT_END = 3'(CMP_LAT);
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  state_e           state_q, state_d;
  logic [31:0]      cur_q, cur_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic             have_q, have_d;
  logic             nan_q, nan_d;
  logic [IDX_W-1:0] pos_q, pos_d;
  logic [31:0]      x_q, x_d;
  logic [IDX_W-1:0] x_idx_q, x_idx_d;
  logic             last_q, last_d;
  logic             mode_q, mode_d;
  logic [2:0]       wcnt_q, wcnt_d;
  logic             rdy_q, rdy_d;
  logic [30:0]      opa_q, opa_d;
  logic [30:0]      opb_q, opb_d;

  logic xfer;
  logic in_nan;
  logic swap;
  logic same_sign;
  logic both_zero;
  logic repl;
  logic done;

  assign xfer   = io.in_valid & rdy_q;
  assign in_nan = (&io.in_data[30:23]) & (|io.in_data[22:0]);

  // A = current value when ordering must be inverted: max on positives,
  // min on negatives (larger magnitude is the smaller number).
  assign swap = mode_q ^ io.in_data[31];

  assign same_sign = x_q[31] == cur_q[31];
  assign both_zero = ~(|x_q[30:0]) & ~(|cur_q[30:0]);
  assign repl      = same_sign ? cmp_res
                   : (~both_zero & (mode_q ? ~x_q[31] : x_q[31]));

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    cur_idx_d = cur_idx_q;
    have_d    = have_q;
    nan_d     = nan_q;
    pos_d     = pos_q;
    x_d       = x_q;
    x_idx_d   = x_idx_q;
    last_d    = last_q;
    mode_d    = mode_q;
    wcnt_d    = wcnt_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          mode_d    = mode;
          pos_d     = IDX_W'(1);
          cur_idx_d = '0;
          if (in_nan) begin
            nan_d  = 1'b1;
            have_d = 1'b0;
          end else begin
            cur_d  = io.in_data;
            have_d = 1'b1;
          end
          state_d = io.in_last ? DONE : ACCEPT;
        end
      end
      ACCEPT: begin
        if (xfer) begin
          pos_d = pos_q + IDX_W'(1);
          if (!in_nan && have_q) begin
            x_d     = io.in_data;
            x_idx_d = pos_q;
            last_d  = io.in_last;
            wcnt_d  = '0;
            opa_d   = swap ? cur_q[30:0] : io.in_data[30:0];
            opb_d   = swap ? io.in_data[30:0] : cur_q[30:0];
            state_d = WAIT;
          end else begin
            if (in_nan) begin
              nan_d = 1'b1;
            end else begin
              cur_d     = io.in_data;
              cur_idx_d = pos_q;
              have_d    = 1'b1;
            end
            state_d = io.in_last ? DONE : ACCEPT;
          end
        end
      end
      WAIT: begin
        if (wcnt_q == WAIT_END) begin
          if (repl) begin
            cur_d     = x_q;
            cur_idx_d = x_idx_q;
          end
          state_d = last_q ? DONE : ACCEPT;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          nan_d   = 1'b0;
          have_d  = 1'b0;
          pos_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered so it stays low throughout reset and rises one edge later.
  assign rdy_d = (state_d == IDLE) | (state_d == ACCEPT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      cur_idx_q <= '0;
      have_q    <= 1'b0;
      nan_q     <= 1'b0;
      pos_q     <= '0;
      x_q       <= '0;
      x_idx_q   <= '0;
      last_q    <= 1'b0;
      mode_q    <= 1'b0;
      wcnt_q    <= '0;
      rdy_q     <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      cur_idx_q <= cur_idx_d;
      have_q    <= have_d;
      nan_q     <= nan_d;
      pos_q     <= pos_d;
      x_q       <= x_d;
      x_idx_q   <= x_idx_d;
      last_q    <= last_d;
      mode_q    <= mode_d;
      wcnt_q    <= wcnt_d;
      rdy_q     <= rdy_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
    end
  end

  assign done = state_q == DONE;

  assign io.in_ready  = rdy_q;
  assign io.out_valid = done;
  assign io.out_value = !done ? '0 : (have_q ? cur_q : QNAN);
  assign io.out_idx   = (done & have_q) ? cur_idx_q : '0;
  assign io.out_nan   = done & nan_q;

  assign cmp_a_exp = opa_q[30:23];
  assign cmp_a_man = opa_q[22:0];
  assign cmp_b_exp = opb_q[30:23];
  assign cmp_b_man = opb_q[22:0];

endmodule

// File: tb/tb_fp_cmp_minmax_seq.sv
// Directed bench for fp_cmp_minmax_seq with CMP_LAT=3 and a delay-line
// comparator model that can be overridden to inject early garbage.
module tb_fp_cmp_minmax_seq;
  localparam int LAT = 3;
  localparam int IW  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic [7:0]  cax, cbx;
  logic [22:0] cam, cbm;
  logic        cmp_res;
  logic        man_en = 1'b0;
  logic        man_val = 1'b0;
  logic [2:0]  pipe = '0;
  int          total = 0;
  int          bad = 0;

  fp_cmp_minmax_seq_if #(.IDX_W(IW)) bus ();

  fp_cmp_minmax_seq #(.CMP_LAT(LAT), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .io        (bus),
    .cmp_a_exp (cax),
    .cmp_a_man (cam),
    .cmp_b_exp (cbx),
    .cmp_b_man (cbm),
    .cmp_res   (cmp_res)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pipe <= {pipe[1:0], ({cax, cam} < {cbx, cbm})};
  assign cmp_res = man_en ? man_val : pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic m);
    int n = 0;
    bus.in_data  = d;
    bus.in_last  = l;
    mode         = m;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $error("FAIL send_timeout observed=in_ready_low expected=in_ready");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic result(input string tag, input logic [31:0] v,
                        input logic [31:0] idx, input logic nan,
                        input int hold);
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $error("FAIL %s_timeout observed=no_out_valid expected=out_valid", tag);
    end
    chk({tag, "_val"}, bus.out_value, v);
    chk({tag, "_idx"}, 32'(bus.out_idx), idx);
    chk({tag, "_nan"}, 32'(bus.out_nan), 32'(nan));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_vld"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_val"}, bus.out_value, v);
      chk({tag, "_hold_idx"}, 32'(bus.out_idx), idx);
      chk({tag, "_hold_rdy"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_clr"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic wait_window(input string tag, input logic [31:0] a,
                             input logic [31:0] b, input logic early,
                             input logic final_v);
    for (int i = 0; i < LAT + 1; i++) begin
      chk({tag, "_opa"}, {1'b0, cax, cam}, a);
      chk({tag, "_opb"}, {1'b0, cbx, cbm}, b);
      chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_vld"}, 32'(bus.out_valid), 32'd0);
      man_val = (i == LAT) ? final_v : early;
      if (i < LAT) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_value", bus.out_value, 32'd0);
    chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
    chk("rst_out_nan", 32'(bus.out_nan), 32'd0);
    chk("rst_cmp_a", {1'b0, cax, cam}, 32'd0);
    chk("rst_cmp_b", {1'b0, cbx, cbm}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

    send(32'h4040_0000, 1'b0, 1'b0);
    send(32'hBFC0_0000, 1'b0, 1'b0);
    send(32'h4000_0000, 1'b1, 1'b0);
    result("min_mixed", 32'hBFC0_0000, 32'd1, 1'b0, 0);

    send(32'h3F80_0000, 1'b0, 1'b1);
    send(32'h3F80_0000, 1'b1, 1'b1);
    result("max_tie", 32'h3F80_0000, 32'd0, 1'b0, 0);

    send(32'h0000_0000, 1'b0, 1'b0);
    send(32'h8000_0000, 1'b1, 1'b0);
    result("min_zeros", 32'h0000_0000, 32'd0, 1'b0, 0);

    send(32'h7FC0_0001, 1'b0, 1'b0);
    send(32'h40A0_0000, 1'b1, 1'b0);
    result("nan_first", 32'h40A0_0000, 32'd1, 1'b1, 0);

    send(32'h7F80_0001, 1'b1, 1'b0);
    result("nan_only", 32'h7FC0_0000, 32'd0, 1'b1, 0);

    send(32'hC000_0000, 1'b0, 1'b1);
    send(32'hBF80_0000, 1'b0, 1'b1);
    send(32'hC040_0000, 1'b1, 1'b1);
    result("max_neg", 32'hBF80_0000, 32'd1, 1'b0, 0);

    send(32'hFF80_0000, 1'b0, 1'b1);
    send(32'h7F80_0000, 1'b1, 1'b1);
    result("max_inf", 32'h7F80_0000, 32'd1, 1'b0, 0);

    send(32'h40A0_0000, 1'b0, 1'b0);
    send(32'h4040_0000, 1'b0, 1'b0);
    send(32'h3F80_0000, 1'b1, 1'b0);
    result("min_pos_hold", 32'h3F80_0000, 32'd2, 1'b0, 5);

    send(32'h4000_0000, 1'b0, 1'b0);
    man_en  = 1'b1;
    man_val = 1'b0;
    send(32'h3F80_0000, 1'b1, 1'b0);
    wait_window("lat_repl", 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b1);
    result("lat_repl", 32'h3F80_0000, 32'd1, 1'b0, 0);

    send(32'h3F80_0000, 1'b0, 1'b0);
    man_val = 1'b1;
    send(32'h4000_0000, 1'b1, 1'b0);
    wait_window("lat_keep", 32'h4000_0000, 32'h3F80_0000, 1'b1, 1'b0);
    result("lat_keep", 32'h3F80_0000, 32'd0, 1'b0, 0);
    man_en = 1'b0;

    send(32'h7FC0_0000, 1'b0, 1'b1);
    send(32'h3F80_0000, 1'b0, 1'b1);
    send(32'h4000_0000, 1'b0, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_vld", 32'(bus.out_valid), 32'd0);
    chk("abort_rdy", 32'(bus.in_ready), 32'd0);
    chk("abort_nan", 32'(bus.out_nan), 32'd0);
    chk("abort_cmp_a", {1'b0, cax, cam}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ready", 32'(bus.in_ready), 32'd1);
    send(32'h4100_0000, 1'b0, 1'b0);
    send(32'h40E0_0000, 1'b1, 1'b0);
    result("after_abort", 32'h40E0_0000, 32'd1, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
